// File: rtl/torture_pkg.sv
// torture_pkg: shared definitions for the picorv32 torture-run memory responder.
//   state_t      : top-level controller states
//   DEFAULT_SEED : power-on xorshift32 state
//   xorshift32() : one step of the 13/17/5 xorshift32 generator, also used by
//                  software models to predict the grant pattern
package torture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [31:0] DEFAULT_SEED = 32'd314159265;

    function automatic logic [31:0] xorshift32(input logic [31:0] x);
        logic [31:0] v;
        v = x;
        v = v ^ (v << 13);
        v = v ^ (v >> 17);
        v = v ^ (v << 5);
        return v;
    endfunction

endpackage

// File: rtl/torture_xorshift32.sv
// torture_xorshift32: xorshift32 state register.
//   clk, resetn : clock, synchronous active-low reset (reloads SEED)
//   en          : advance the generator by one step this cycle
//   value       : current generator state
//   next_value  : value the register takes on the next enabled edge
module torture_xorshift32
    import torture_pkg::*;
#(
    parameter logic [31:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        en,
    output logic [31:0] value,
    output logic [31:0] next_value
);

    assign next_value = xorshift32(value);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            value <= SEED;
        end else if (en) begin
            value <= next_value;
        end
    end

endmodule

// File: rtl/torture_memory.sv
// torture_memory: memory responder and signature checker for picorv32 torture runs.
//   clk, resetn           : clock, synchronous active-low reset
//   core_resetn           : release-from-reset driven to the core
//   trap                  : core trap, ends the run and starts the signature check
//   mem_valid/instr/addr/wdata/wstrb : core native request
//   mem_la_read/write/addr/wdata/wstrb : core look-ahead request
//   mem_ready, mem_rdata  : one-cycle response pulse and read data
//   ld_en/sel/addr/data   : preload port for main (sel=0) or reference (sel=1) array
//   done, pass, timeout   : run outcome (sticky until reset)
//   err_count             : number of mismatching words
//   first_err_addr        : byte address of the lowest mismatching word
module torture_memory
    import torture_pkg::*;
#(
    parameter int          MEM_WORDS    = 4096,
    parameter int          ADDR_BITS    = 12,
    parameter logic [31:0] SEED         = DEFAULT_SEED,
    parameter int          RESET_CYCLES = 10,
    parameter int          TIMEOUT      = 100000
) (
    input  logic                 clk,
    input  logic                 resetn,
    output logic                 core_resetn,
    input  logic                 trap,
    input  logic                 mem_valid,
    input  logic                 mem_instr,
    input  logic [31:0]          mem_addr,
    input  logic [31:0]          mem_wdata,
    input  logic [3:0]           mem_wstrb,
    output logic                 mem_ready,
    output logic [31:0]          mem_rdata,
    input  logic                 mem_la_read,
    input  logic                 mem_la_write,
    input  logic [31:0]          mem_la_addr,
    input  logic [31:0]          mem_la_wdata,
    input  logic [3:0]           mem_la_wstrb,
    input  logic                 ld_en,
    input  logic                 ld_sel,
    input  logic [ADDR_BITS-1:0] ld_addr,
    input  logic [31:0]          ld_data,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout,
    output logic [ADDR_BITS:0]   err_count,
    output logic [31:0]          first_err_addr
);

    localparam logic [31:0]          RELEASE_CYCLE = 32'(RESET_CYCLES + 1);
    localparam logic [ADDR_BITS+1:0] CHK_LAST_CMP  = (ADDR_BITS+2)'(MEM_WORDS);
    localparam logic [ADDR_BITS+1:0] CHK_FINISH    = (ADDR_BITS+2)'(MEM_WORDS + 1);

    state_t               state, state_next;
    logic [31:0]          cycle;
    logic [ADDR_BITS+1:0] chk_cnt;
    logic [ADDR_BITS+1:0] cmp_idx_full;
    logic [31:0]          x32, x32_next;
    logic                 grant, run_timeout;
    logic                 serve, do_la_read, do_la_write, do_native, native_write;
    logic                 rdata_valid;

    logic                 main_we, ref_we;
    logic [ADDR_BITS-1:0] main_widx, main_ridx;
    logic [31:0]          main_wdata;
    logic [3:0]           main_wstrb;
    logic [31:0]          main_q, ref_q;
    logic [31:0]          main_mem [MEM_WORDS];
    logic [31:0]          ref_mem  [MEM_WORDS];

    logic                 unused_bits;

    torture_xorshift32 #(.SEED(SEED)) u_rng (
        .clk        (clk),
        .resetn     (resetn),
        .en         (state == ST_RUN),
        .value      (x32),
        .next_value (x32_next)
    );

    assign grant        = x32[0];
    assign run_timeout  = (cycle - 32'(RESET_CYCLES)) > 32'(TIMEOUT);
    assign cmp_idx_full = chk_cnt - 1'b1;

    // Response arbitration: look-ahead read, then look-ahead write, then native.
    // A trap cycle never produces a response, and native is skipped while its
    // previous response is still on the bus.
    assign serve        = resetn && (state == ST_RUN) && grant && !trap;
    assign do_la_read   = serve && mem_la_read;
    assign do_la_write  = serve && !mem_la_read && mem_la_write;
    assign do_native    = serve && !mem_la_read && !mem_la_write && mem_valid && !mem_ready;
    assign native_write = do_native && (mem_wstrb != 4'b0000);

    assign ref_we = resetn && (state == ST_IDLE) && ld_en && ld_sel;

    always_comb begin
        main_we    = 1'b0;
        main_widx  = ld_addr;
        main_wdata = ld_data;
        main_wstrb = 4'b1111;
        if (resetn && (state == ST_IDLE) && ld_en && !ld_sel) begin
            main_we = 1'b1;
        end else if (do_la_write) begin
            main_we    = 1'b1;
            main_widx  = mem_la_addr[ADDR_BITS+1:2];
            main_wdata = mem_la_wdata;
            main_wstrb = mem_la_wstrb;
        end else if (native_write) begin
            main_we    = 1'b1;
            main_widx  = mem_addr[ADDR_BITS+1:2];
            main_wdata = mem_wdata;
            main_wstrb = mem_wstrb;
        end
    end

    // The single read port of the main array is shared between the core and
    // the signature walk; the two never overlap in time.
    always_comb begin
        main_ridx = mem_addr[ADDR_BITS+1:2];
        if (state == ST_CHECK) begin
            main_ridx = chk_cnt[ADDR_BITS-1:0];
        end else if (mem_la_read) begin
            main_ridx = mem_la_addr[ADDR_BITS+1:2];
        end
    end

    always_ff @(posedge clk) begin
        if (main_we) begin
            for (int k = 0; k < 4; k++) begin
                if (main_wstrb[k]) begin
                    main_mem[main_widx][8*k +: 8] <= main_wdata[8*k +: 8];
                end
            end
        end
        main_q <= main_mem[main_ridx];
    end

    always_ff @(posedge clk) begin
        if (ref_we) begin
            ref_mem[ld_addr] <= ld_data;
        end
        ref_q <= ref_mem[chk_cnt[ADDR_BITS-1:0]];
    end

    assign mem_rdata = (mem_ready && rdata_valid) ? main_q : 32'h0;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Trap is tested before the timeout so it wins when both occur together.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (cycle == RELEASE_CYCLE) state_next = ST_RUN;
            ST_RUN: begin
                if (trap) begin
                    state_next = ST_CHECK;
                end else if (run_timeout) begin
                    state_next = ST_DONE;
                end
            end
            ST_CHECK: if (chk_cnt == CHK_FINISH) state_next = ST_DONE;
            ST_DONE:  state_next = ST_DONE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // chk_cnt = c issues the read of word c and compares word c-1, whose data
    // arrived from both arrays on the previous edge. One extra step after the
    // last compare lets pass see the final err_count.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cycle          <= 32'h0;
            chk_cnt        <= '0;
            core_resetn    <= 1'b0;
            mem_ready      <= 1'b0;
            rdata_valid    <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            err_count      <= '0;
            first_err_addr <= 32'h0;
        end else begin
            mem_ready   <= do_la_read || do_la_write || do_native;
            rdata_valid <= do_la_read || (do_native && !native_write);
            case (state)
                ST_IDLE: begin
                    cycle <= cycle + 32'd1;
                    if (cycle == RELEASE_CYCLE) core_resetn <= 1'b1;
                end
                ST_RUN: begin
                    cycle   <= cycle + 32'd1;
                    chk_cnt <= '0;
                    if (!trap && run_timeout) begin
                        done    <= 1'b1;
                        timeout <= 1'b1;
                        pass    <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    chk_cnt <= chk_cnt + 1'b1;
                    if ((chk_cnt != '0) && (chk_cnt <= CHK_LAST_CMP) && (main_q != ref_q)) begin
                        err_count <= err_count + 1'b1;
                        if (err_count == '0) begin
                            first_err_addr <= 32'({cmp_idx_full[ADDR_BITS-1:0], 2'b00});
                        end
                    end
                    if (chk_cnt == CHK_FINISH) begin
                        done <= 1'b1;
                        pass <= (err_count == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign unused_bits = ^{mem_instr, mem_addr[31:ADDR_BITS+2], mem_addr[1:0],
                           mem_la_addr[31:ADDR_BITS+2], mem_la_addr[1:0],
                           x32[31:1], x32_next, cmp_idx_full[ADDR_BITS+1:ADDR_BITS]};

endmodule

// File: tb/tb_torture_memory.sv
// tb_torture_memory: scoreboard bench for torture_memory.
// Preloads both arrays through short IDLE windows, drives granted and
// ungranted requests predicted by an independent xorshift32 model, then
// exercises signature pass/fail, timeout, trap-vs-timeout and mid-check reset.
module tb_torture_memory;

    localparam int          MEM_WORDS    = 4096;
    localparam int          ADDR_BITS    = 12;
    localparam int          RESET_CYCLES = 10;
    localparam int          TIMEOUT      = 2000;
    localparam logic [31:0] SEED         = 32'd314159265;
    localparam int          CHECK_CYCLES = MEM_WORDS + 2;

    logic                 clk = 1'b0;
    logic                 resetn = 1'b0;
    logic                 core_resetn;
    logic                 trap = 1'b0;
    logic                 mem_valid = 1'b0, mem_instr = 1'b0;
    logic [31:0]          mem_addr = '0, mem_wdata = '0;
    logic [3:0]           mem_wstrb = '0;
    logic                 mem_ready;
    logic [31:0]          mem_rdata;
    logic                 mem_la_read = 1'b0, mem_la_write = 1'b0;
    logic [31:0]          mem_la_addr = '0, mem_la_wdata = '0;
    logic [3:0]           mem_la_wstrb = '0;
    logic                 ld_en = 1'b0, ld_sel = 1'b0;
    logic [ADDR_BITS-1:0] ld_addr = '0;
    logic [31:0]          ld_data = '0;
    logic                 done, pass, timeout;
    logic [ADDR_BITS:0]   err_count;
    logic [31:0]          first_err_addr;

    int          total = 0;
    int          bad = 0;
    int          win = 11;
    logic [31:0] model_x;
    logic        exp_ready_prev;
    logic [31:0] main_model [MEM_WORDS];
    logic [32:0] sb [$];

    torture_memory #(
        .MEM_WORDS(MEM_WORDS), .ADDR_BITS(ADDR_BITS), .SEED(SEED),
        .RESET_CYCLES(RESET_CYCLES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .resetn(resetn), .core_resetn(core_resetn), .trap(trap),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .mem_la_read(mem_la_read), .mem_la_write(mem_la_write),
        .mem_la_addr(mem_la_addr), .mem_la_wdata(mem_la_wdata), .mem_la_wstrb(mem_la_wstrb),
        .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
        .done(done), .pass(pass), .timeout(timeout), .err_count(err_count),
        .first_err_addr(first_err_addr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] stepRng(input logic [31:0] x);
        logic [31:0] t;
        t = x ^ {x[18:0], 13'b0};
        t = t ^ {17'b0, t[31:17]};
        t = t ^ {t[26:0], 5'b0};
        return t;
    endfunction

    function automatic logic [31:0] pattern(input int i);
        return 32'(i) * 32'h9E3779B1 + 32'h12345678;
    endfunction

    function automatic logic [31:0] mainInit(input int i);
        if (i == 0) return 32'h00000013;
        if (i == 1) return 32'h11223344;
        return pattern(i);
    endfunction

    function automatic logic [31:0] refInit(input int i);
        if (i == 0) return 32'h00000013;
        if (i == 1) return 32'h11BB33DD;
        if (i == 2) return 32'hCAFEF00D;
        return pattern(i);
    endfunction

    function automatic logic [31:0] laneMerge(input logic [31:0] old, input logic [31:0] nw,
                                              input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) if (strb[k]) r[8*k +: 8] = nw[8*k +: 8];
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_core_resetn"}, 32'(core_resetn), 32'h0);
        checkOutput({tag, "_mem_ready"}, 32'(mem_ready), 32'h0);
        checkOutput({tag, "_mem_rdata"}, mem_rdata, 32'h0);
        checkOutput({tag, "_done"}, 32'(done), 32'h0);
        checkOutput({tag, "_pass"}, 32'(pass), 32'h0);
        checkOutput({tag, "_timeout"}, 32'(timeout), 32'h0);
        checkOutput({tag, "_err_count"}, 32'(err_count), 32'h0);
        checkOutput({tag, "_first_err"}, first_err_addr, 32'h0);
    endtask

    task automatic startWindow();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        win = 0;
    endtask

    task automatic loadWord(input logic sel, input int addr, input logic [31:0] data);
        if (win >= 11) startWindow();
        ld_en = 1'b1; ld_sel = sel; ld_addr = ADDR_BITS'(addr); ld_data = data;
        tick();
        ld_en = 1'b0;
        win++;
    endtask

    task automatic startRun(input string tag);
        startWindow();
        for (int k = 1; k <= RESET_CYCLES + 2; k++) begin
            tick();
            if (k <= RESET_CYCLES + 1) begin
                checkOutput({tag, "_core_resetn_low"}, 32'(core_resetn), 32'h0);
                checkOutput({tag, "_no_ready_idle"}, 32'(mem_ready), 32'h0);
            end else begin
                checkOutput({tag, "_core_resetn_high"}, 32'(core_resetn), 32'h1);
            end
        end
        model_x = SEED;
        exp_ready_prev = 1'b0;
        win = 11;
    endtask

    // Drives one RUN cycle, predicts the response from the model and checks it.
    task automatic applyStimulus(input string tag, input logic la_rd, input logic la_wr,
                                 input logic mv, input logic tr,
                                 input logic [31:0] la_a, input logic [31:0] la_d,
                                 input logic [3:0] la_s, input logic [31:0] m_a,
                                 input logic [31:0] m_d, input logic [3:0] m_s);
        logic        exp_rdy;
        logic [31:0] exp_data;
        logic [32:0] exp;
        mem_la_read = la_rd; mem_la_write = la_wr; mem_la_addr = la_a;
        mem_la_wdata = la_d; mem_la_wstrb = la_s;
        mem_valid = mv; mem_addr = m_a; mem_wdata = m_d; mem_wstrb = m_s; trap = tr;
        exp_rdy = 1'b0;
        exp_data = 32'h0;
        if (model_x[0] && !tr) begin
            if (la_rd) begin
                exp_rdy = 1'b1;
                exp_data = main_model[la_a[ADDR_BITS+1:2]];
            end else if (la_wr) begin
                exp_rdy = 1'b1;
                main_model[la_a[ADDR_BITS+1:2]] = laneMerge(main_model[la_a[ADDR_BITS+1:2]], la_d, la_s);
            end else if (mv && !exp_ready_prev) begin
                exp_rdy = 1'b1;
                if (m_s != 4'b0000)
                    main_model[m_a[ADDR_BITS+1:2]] = laneMerge(main_model[m_a[ADDR_BITS+1:2]], m_d, m_s);
                else
                    exp_data = main_model[m_a[ADDR_BITS+1:2]];
            end
        end
        sb.push_back({exp_rdy, exp_data});
        exp_ready_prev = exp_rdy;
        model_x = stepRng(model_x);
        tick();
        mem_la_read = 1'b0; mem_la_write = 1'b0; mem_valid = 1'b0; trap = 1'b0;
        exp = sb.pop_front();
        checkOutput({tag, "_ready"}, 32'(mem_ready), 32'(exp[32]));
        checkOutput({tag, "_rdata"}, mem_rdata, exp[31:0]);
    endtask

    task automatic idleCycle();
        applyStimulus("idle", 0, 0, 0, 0, '0, '0, '0, '0, '0, '0);
    endtask

    task automatic waitGrant();
        for (int n = 0; n < 64 && !model_x[0]; n++) idleCycle();
    endtask

    task automatic laRead(input string tag, input logic [31:0] a);
        waitGrant();
        applyStimulus(tag, 1, 0, 0, 0, a, '0, '0, '0, '0, '0);
    endtask

    task automatic pulseTrap();
        trap = 1'b1;
        tick();
        trap = 1'b0;
    endtask

    task automatic waitDone(input string tag);
        for (int k = 1; k <= CHECK_CYCLES; k++) begin
            tick();
            if (k == CHECK_CYCLES - 1) checkOutput({tag, "_done_early"}, 32'(done), 32'h0);
            if (k % 1024 == 0) begin
                checkOutput({tag, "_check_ready"}, 32'(mem_ready), 32'h0);
                checkOutput({tag, "_check_core_resetn"}, 32'(core_resetn), 32'h1);
            end
        end
        checkOutput({tag, "_done"}, 32'(done), 32'h1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("reset");

        for (int i = 0; i < MEM_WORDS; i++) begin
            main_model[i] = mainInit(i);
            loadWord(1'b0, i, mainInit(i));
            loadWord(1'b1, i, refInit(i));
        end

        // Run 1: responses, lane writes, arbitration, then a matching signature.
        startRun("run1");
        for (int n = 0; n < 64 && model_x[0]; n++) idleCycle();
        applyStimulus("la_rd_nogrant", 1, 0, 0, 0, 32'h0, '0, '0, '0, '0, '0);
        laRead("la_rd_w0", 32'h0);
        idleCycle();
        for (int n = 0; n < 64; n++) begin
            applyStimulus("nat_wr", 0, 0, 1, 0, '0, '0, '0, 32'h4, 32'hAABBCCDD, 4'b0101);
            if (exp_ready_prev) break;
        end
        idleCycle();
        laRead("rd_w1_lanes", 32'h4);
        waitGrant();
        applyStimulus("la_wr_vs_nat", 0, 1, 1, 0, 32'h8, 32'hCAFEF00D, 4'hF,
                      32'hC, 32'hDEADBEEF, 4'hF);
        laRead("rd_w2", 32'h8);
        laRead("rd_w3", 32'hC);
        laRead("rd_wrap", 32'h00004004);
        waitGrant();
        applyStimulus("trap_no_resp", 1, 0, 0, 1, 32'h0, '0, '0, '0, '0, '0);
        waitDone("sig_ok");
        checkOutput("sig_ok_pass", 32'(pass), 32'h1);
        checkOutput("sig_ok_err_count", 32'(err_count), 32'h0);
        checkOutput("sig_ok_timeout", 32'(timeout), 32'h0);

        // Run 2: reference differs at words 3 and the last word.
        loadWord(1'b1, 3, refInit(3) ^ 32'h1);
        loadWord(1'b1, MEM_WORDS - 1, refInit(MEM_WORDS - 1) ^ 32'h80000000);
        startRun("run2");
        pulseTrap();
        waitDone("sig_bad");
        checkOutput("sig_bad_err_count", 32'(err_count), 32'h2);
        checkOutput("sig_bad_first_err", first_err_addr, 32'h0000000C);
        checkOutput("sig_bad_pass", 32'(pass), 32'h0);
        repeat (5) tick();
        checkOutput("done_hold", 32'(done), 32'h1);

        // Run 3: reset in the middle of the walk, then a full rerun.
        startRun("run3");
        pulseTrap();
        repeat (2000) tick();
        checkOutput("midchk_err_count", 32'(err_count), 32'h1);
        resetn = 1'b0;
        tick();
        checkResetOutputs("midchk_reset");
        resetn = 1'b1;
        startRun("run3b");
        pulseTrap();
        waitDone("rerun");
        checkOutput("rerun_err_count", 32'(err_count), 32'h2);
        checkOutput("rerun_first_err", first_err_addr, 32'h0000000C);

        // Run 4: no trap ever arrives.
        startRun("run4");
        for (int k = 1; k <= TIMEOUT; k++) begin
            tick();
            if (k == TIMEOUT - 1) checkOutput("timeout_early", 32'(done), 32'h0);
        end
        checkOutput("timeout_done", 32'(done), 32'h1);
        checkOutput("timeout_flag", 32'(timeout), 32'h1);
        checkOutput("timeout_pass", 32'(pass), 32'h0);

        // Run 5: trap lands on the same cycle the timeout would fire.
        startRun("run5");
        repeat (TIMEOUT - 1) tick();
        pulseTrap();
        checkOutput("trap_vs_to_done", 32'(done), 32'h0);
        checkOutput("trap_vs_to_flag", 32'(timeout), 32'h0);
        waitDone("trap_vs_to");
        checkOutput("trap_vs_to_timeout", 32'(timeout), 32'h0);
        checkOutput("trap_vs_to_err_count", 32'(err_count), 32'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/torture_memory.md
Name: torture_memory

Overview:
- Synthesizable memory responder and signature checker for picorv32 torture runs, sitting directly downstream of the core's native and look-ahead memory interfaces.
- Serves instruction and data accesses with xorshift-randomized grant timing and generates the core's release-from-reset.
- On core trap, walks the whole memory and compares it word by word against a reference signature memory, then reports pass, fail or timeout.

Parameters:
- MEM_WORDS, 4096, number of 32-bit words in the main and reference arrays.
- ADDR_BITS, 12, word-index width; equals log2(MEM_WORDS).
- SEED, 32'd314159265, initial xorshift32 state.
- RESET_CYCLES, 10, core_resetn rises on the edge where the cycle counter equals RESET_CYCLES+1.
- TIMEOUT, 100000, RUN-state cycle limit before timeout.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- core_resetn  out  1  reset driven to the core
- trap  in  1  core trap
- mem_valid, mem_instr  in  1  core native request
- mem_addr, mem_wdata  in  32  native address / write data
- mem_wstrb  in  4  native byte strobes
- mem_ready  out  1  one-cycle response pulse
- mem_rdata  out  32  read data
- mem_la_read, mem_la_write  in  1  look-ahead request
- mem_la_addr, mem_la_wdata  in  32  look-ahead address / data
- mem_la_wstrb  in  4  look-ahead strobes
- ld_en  in  1  preload strobe
- ld_sel  in  1  preload target: 0 = main, 1 = reference
- ld_addr  in  ADDR_BITS  preload word index
- ld_data  in  32  preload data
- done  out  1  run finished (sticky)
- pass  out  1  signature matched, no timeout
- timeout  out  1  timeout occurred
- err_count  out  ADDR_BITS+1  mismatching word count
- first_err_addr  out  32  byte address of the lowest mismatching word

Behaviour:
- Reset: state IDLE; cycle=0; x32=SEED; all outputs 0. Memory contents are retained across reset.
- States: IDLE, RUN, CHECK, DONE.
- IDLE: cycle increments each clock. ld_en writes the selected array at ld_addr. On cycle==RESET_CYCLES+1, core_resetn<=1 and the state moves to RUN. ld_en is ignored in every other state.
- RUN, every cycle:
  - x32 <= xorshift32(x32), shifts <<13, >>17, <<5; grant = x32[0] of the current value.
  - mem_ready<=0 and mem_rdata<=0 by default.
- RUN, when grant=1, priority is:
  - la_read: ready=1, rdata=mem[la_addr[ADDR_BITS+1:2]].
  - la_write: ready=1, write lanes per la_wstrb.
  - mem_valid && !mem_ready: ready=1; write lanes if mem_wstrb!=0, else read.
- Address bits above ADDR_BITS+1 are ignored, so addresses wrap. Byte lane k maps to bits [8k+7:8k].
- RUN exits:
  - trap=1 goes to CHECK; no response in that cycle even if granted.
  - cycle-RESET_CYCLES > TIMEOUT goes to DONE with timeout=1, pass=0.
  - trap beats timeout when both occur in the same cycle.
- CHECK:
  - Index i runs 0..MEM_WORDS-1, one synchronous read of both arrays per cycle; compare one cycle later.
  - A mismatch increments err_count; the first mismatch latches first_err_addr={i,2'b00}.
  - After the last compare the state moves to DONE: done=1, pass=(err_count==0).
  - done rises MEM_WORDS+2 cycles after the cycle in which trap is sampled.
  - core_resetn stays 1 and mem_ready stays 0 throughout CHECK.
- DONE: terminal; outputs hold until resetn.
- resetn low in any state, including mid-CHECK: all state and outputs return to reset values next edge.
- mem_rdata is 0 whenever mem_ready=0.

Decomposition:
- Package torture_pkg holds:
  - the state enum;
  - the default SEED;
  - the xorshift32 function, shared with software models.
- One sub-module, torture_xorshift32: enable, state register, next-value output.
- Memories are inferred as two simple dual-port RAMs inside torture_memory.

Test Plan:
- Reset release: resetn high at cycle 0 -> core_resetn=0 through the edge where cycle=11, 1 after it; no mem_ready before that.
- Look-ahead read: preload main[0]=0x00000013; la_read addr 0x0 on a granted cycle -> mem_ready=1 for exactly one cycle with mem_rdata=0x00000013. Grant cycles match the software xorshift32 from SEED.
- Lane write: main[1]=0x11223344; native write addr 0x4, wstrb=4'b0101, wdata 0xAABBCCDD -> main[1]=0x11BB33DD. Also check that mem_la_write beats mem_valid in the same granted cycle.
- Signature fail: reference differs at words 3 and 4095; pulse trap -> done after 4098 cycles, err_count=2, first_err_addr=0x0000000C, pass=0. With identical arrays -> pass=1, err_count=0.
- Timeout: trap never asserted -> done=1, timeout=1, pass=0 at RUN cycle 100001. trap and timeout in the same cycle -> CHECK is entered.
- Mid-check reset: drop resetn during CHECK -> all outputs 0 next edge; rerun with memory intact gives the same err_count.
